// File: rtl/fx2_sched_pkg.sv
// Shared types, FIFOADR encodings and small helpers for the FX2 slave-FIFO scheduler.
package fx2_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN,
        ST_RX,
        ST_TX,
        ST_PKTEND
    } state_e;

    localparam logic [1:0] ADR_FIFO2 = 2'b00;
    localparam logic [1:0] ADR_FIFO4 = 2'b10;
    localparam logic [1:0] ADR_FIFO5 = 2'b11;

    localparam int NUM_REQ   = 3;
    localparam int REQ_FIFO2 = 0;
    localparam int REQ_FIFO4 = 1;
    localparam int REQ_FIFO5 = 2;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [1:0] onehot_to_adr(input logic [NUM_REQ-1:0] oh);
        logic [1:0] adr;
        case (oh)
            3'b010:  adr = ADR_FIFO4;
            3'b100:  adr = ADR_FIFO5;
            default: adr = ADR_FIFO2;
        endcase
        return adr;
    endfunction

endpackage

// File: rtl/fx2_rr_arbiter.sv
// Three-way round-robin arbiter: one-hot grant searched from the pointer,
// pointer moves past the owner when the owner releases the bus.
module fx2_rr_arbiter
    import fx2_sched_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               release_i,
    input  logic [NUM_REQ-1:0] owner_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic [1:0] idx0;
    logic [1:0] idx1;
    logic [1:0] idx2;

    assign idx0 = ptr_q;
    assign idx1 = rr_next(idx0);
    assign idx2 = rr_next(idx1);

    always_comb begin
        grant_o = '0;
        if (req_i[idx0]) begin
            grant_o[idx0] = 1'b1;
        end else if (req_i[idx1]) begin
            grant_o[idx1] = 1'b1;
        end else if (req_i[idx2]) begin
            grant_o[idx2] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (release_i) begin
            ptr_d = rr_next(onehot_to_idx(owner_i));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 2'(REQ_FIFO2);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fx2_fifo_scheduler.sv
// Shares the FX2 slave-FIFO bus between the FIFO2 RX stream and the FIFO4/FIFO5
// TX streams with round-robin bounded bursts, address turnaround and PKTEND commit.
//
//   state     | meaning
//   ST_IDLE   | no grant; pick next requester, latch FIFOADR
//   ST_TURN   | bus idle for TURN_CYCLES after a FIFOADR change
//   ST_RX     | reading FIFO2 into rx_data
//   ST_TX     | writing the granted TX channel onto FD
//   ST_PKTEND | one-cycle packet commit on the current FIFOADR
module fx2_fifo_scheduler
    import fx2_sched_pkg::*;
#(
    parameter int MAX_BURST   = 64,
    parameter int TURN_CYCLES = 1
) (
    input  logic       FX2_CLK,
    input  logic       reset,
    input  logic       FIFO2_data_available,
    input  logic       FIFO4_ready_to_accept_data,
    input  logic       FIFO5_ready_to_accept_data,
    input  logic [7:0] FIFO_DATAIN,
    output logic [7:0] FIFO_DATAOUT,
    output logic       FIFO_DATAOUT_OE,
    output logic       FIFO_DATAIN_OE,
    output logic       FIFO_RD,
    output logic       FIFO_WR,
    output logic       FIFO_PKTEND,
    output logic [1:0] FIFO_FIFOADR,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx4_data,
    input  logic       tx4_valid,
    input  logic       tx4_last,
    output logic       tx4_ready,
    input  logic [7:0] tx5_data,
    input  logic       tx5_valid,
    input  logic       tx5_last,
    output logic       tx5_ready
);

    localparam int CW = $clog2(MAX_BURST + 1);

    state_e             state_q;
    logic [1:0]         adr_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [CW-1:0]      cnt_q;
    logic [1:0]         turn_q;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] arb_grant;
    logic [1:0]         grant_adr;
    logic               strobe;
    logic               last_byte;
    logic               burst_full;
    logic               burst_stop;
    logic               to_pktend;
    logic               in_burst;
    logic               release_pulse;

    assign req[REQ_FIFO2] = FIFO2_data_available & rx_ready;
    assign req[REQ_FIFO4] = tx4_valid & FIFO4_ready_to_accept_data;
    assign req[REQ_FIFO5] = tx5_valid & FIFO5_ready_to_accept_data;

    fx2_rr_arbiter u_arb (
        .clk_i     (FX2_CLK),
        .rst_i     (reset),
        .req_i     (req),
        .release_i (release_pulse),
        .owner_i   (gnt_q),
        .grant_o   (arb_grant)
    );

    assign grant_adr    = onehot_to_adr(arb_grant);
    assign FIFO_FIFOADR = adr_q;
    assign FIFO_PKTEND  = (state_q == ST_PKTEND);
    assign rx_data      = FIFO_DATAIN;

    // Strobes and enables follow the live request flags so a dropped flag
    // suppresses the strobe in the same cycle.
    always_comb begin
        rx_valid        = 1'b0;
        FIFO_RD         = 1'b0;
        FIFO_WR         = 1'b0;
        tx4_ready       = 1'b0;
        tx5_ready       = 1'b0;
        FIFO_DATAOUT    = '0;
        FIFO_DATAOUT_OE = 1'b0;
        FIFO_DATAIN_OE  = 1'b0;
        last_byte       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                FIFO_DATAIN_OE = (adr_q == ADR_FIFO2);
            end
            ST_TURN: begin
                FIFO_DATAIN_OE = gnt_q[REQ_FIFO2];
            end
            ST_RX: begin
                FIFO_DATAIN_OE = 1'b1;
                rx_valid       = FIFO2_data_available;
                FIFO_RD        = FIFO2_data_available & rx_ready;
            end
            ST_TX: begin
                FIFO_DATAOUT_OE = 1'b1;
                if (gnt_q[REQ_FIFO4]) begin
                    FIFO_DATAOUT = tx4_data;
                    FIFO_WR      = tx4_valid & FIFO4_ready_to_accept_data;
                    tx4_ready    = tx4_valid & FIFO4_ready_to_accept_data;
                    last_byte    = tx4_last;
                end else begin
                    FIFO_DATAOUT = tx5_data;
                    FIFO_WR      = tx5_valid & FIFO5_ready_to_accept_data;
                    tx5_ready    = tx5_valid & FIFO5_ready_to_accept_data;
                    last_byte    = tx5_last;
                end
            end
            default: begin
                FIFO_DATAIN_OE = 1'b0;
            end
        endcase
    end

    assign strobe        = FIFO_RD | FIFO_WR;
    assign burst_full    = (cnt_q == CW'(MAX_BURST - 1));
    assign burst_stop    = ~strobe | burst_full;
    assign to_pktend     = FIFO_WR & last_byte;
    assign in_burst      = (state_q == ST_RX) || (state_q == ST_TX);
    assign release_pulse = (in_burst && burst_stop && !to_pktend) || (state_q == ST_PKTEND);

    always_ff @(posedge FX2_CLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            adr_q   <= ADR_FIFO2;
            gnt_q   <= 3'b001;
            cnt_q   <= '0;
            turn_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (|req) begin
                        gnt_q <= arb_grant;
                        adr_q <= grant_adr;
                        if (grant_adr != adr_q) begin
                            state_q <= ST_TURN;
                            turn_q  <= 2'(TURN_CYCLES - 1);
                        end else begin
                            state_q <= arb_grant[REQ_FIFO2] ? ST_RX : ST_TX;
                        end
                    end
                end
                ST_TURN: begin
                    if (turn_q == 2'd0) begin
                        state_q <= gnt_q[REQ_FIFO2] ? ST_RX : ST_TX;
                    end else begin
                        turn_q <= turn_q - 2'd1;
                    end
                end
                ST_RX, ST_TX: begin
                    if (to_pktend) begin
                        state_q <= ST_PKTEND;
                        cnt_q   <= '0;
                    end else if (burst_stop) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_PKTEND: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fx2_fifo_scheduler.sv
// Scoreboard bench for fx2_fifo_scheduler: bench-side FX2 FIFO / stream models feed
// the DUT, expected bytes are queued at load time and a negedge monitor checks them.
module tb_fx2_fifo_scheduler;

    localparam int MAXB = 4;

    logic       FX2_CLK = 1'b0;
    logic       reset   = 1'b1;
    logic       FIFO2_data_available;
    logic       FIFO4_ready_to_accept_data;
    logic       FIFO5_ready_to_accept_data;
    logic [7:0] FIFO_DATAIN;
    logic [7:0] FIFO_DATAOUT;
    logic       FIFO_DATAOUT_OE;
    logic       FIFO_DATAIN_OE;
    logic       FIFO_RD;
    logic       FIFO_WR;
    logic       FIFO_PKTEND;
    logic [1:0] FIFO_FIFOADR;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx4_data;
    logic       tx4_valid;
    logic       tx4_last;
    logic       tx4_ready;
    logic [7:0] tx5_data;
    logic       tx5_valid;
    logic       tx5_last;
    logic       tx5_ready;

    fx2_fifo_scheduler #(.MAX_BURST(MAXB), .TURN_CYCLES(1)) dut (
        .FX2_CLK                    (FX2_CLK),
        .reset                      (reset),
        .FIFO2_data_available       (FIFO2_data_available),
        .FIFO4_ready_to_accept_data (FIFO4_ready_to_accept_data),
        .FIFO5_ready_to_accept_data (FIFO5_ready_to_accept_data),
        .FIFO_DATAIN                (FIFO_DATAIN),
        .FIFO_DATAOUT               (FIFO_DATAOUT),
        .FIFO_DATAOUT_OE            (FIFO_DATAOUT_OE),
        .FIFO_DATAIN_OE             (FIFO_DATAIN_OE),
        .FIFO_RD                    (FIFO_RD),
        .FIFO_WR                    (FIFO_WR),
        .FIFO_PKTEND                (FIFO_PKTEND),
        .FIFO_FIFOADR               (FIFO_FIFOADR),
        .rx_data                    (rx_data),
        .rx_valid                   (rx_valid),
        .rx_ready                   (rx_ready),
        .tx4_data                   (tx4_data),
        .tx4_valid                  (tx4_valid),
        .tx4_last                   (tx4_last),
        .tx4_ready                  (tx4_ready),
        .tx5_data                   (tx5_data),
        .tx5_valid                  (tx5_valid),
        .tx5_last                   (tx5_last),
        .tx5_ready                  (tx5_ready)
    );

    always #5 FX2_CLK = ~FX2_CLK;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] src_rx[$];
    logic [8:0] src_tx4[$];
    logic [8:0] src_tx5[$];
    logic [7:0] exp_rx[$];
    logic [8:0] exp_tx4[$];
    logic [8:0] exp_tx5[$];
    int         fifo4_space = 1000;
    int         fifo5_space = 1000;
    logic       rx_ready_en = 1'b0;

    logic [1:0] grant_log[$];
    int         len_log[$];
    logic [1:0] eg_q[$];
    int         el_q[$];
    int         wr4_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic push_rx(input logic [7:0] d);
        src_rx.push_back(d);
        exp_rx.push_back(d);
    endtask

    task automatic push_tx4(input logic last, input logic [7:0] d);
        src_tx4.push_back({last, d});
        exp_tx4.push_back({last, d});
    endtask

    task automatic push_tx5(input logic last, input logic [7:0] d);
        src_tx5.push_back({last, d});
        exp_tx5.push_back({last, d});
    endtask

    task automatic drive();
        FIFO2_data_available       = (src_rx.size() > 0);
        FIFO_DATAIN                = (src_rx.size() > 0) ? src_rx[0] : 8'h00;
        rx_ready                   = rx_ready_en;
        tx4_valid                  = (src_tx4.size() > 0);
        {tx4_last, tx4_data}       = (src_tx4.size() > 0) ? src_tx4[0] : 9'h000;
        tx5_valid                  = (src_tx5.size() > 0);
        {tx5_last, tx5_data}       = (src_tx5.size() > 0) ? src_tx5[0] : 9'h000;
        FIFO4_ready_to_accept_data = (fifo4_space > 0);
        FIFO5_ready_to_accept_data = (fifo5_space > 0);
    endtask

    // FX2 FIFO and stream source model: consume on strobes sampled mid-cycle.
    initial begin
        logic rd_s, w4_s, w5_s;
        drive();
        forever begin
            @(negedge FX2_CLK);
            rd_s = FIFO_RD;
            w4_s = tx4_ready;
            w5_s = tx5_ready;
            @(posedge FX2_CLK);
            #1;
            if (rd_s && src_rx.size() > 0) void'(src_rx.pop_front());
            if (w4_s && src_tx4.size() > 0) begin
                void'(src_tx4.pop_front());
                if (fifo4_space > 0) fifo4_space--;
            end
            if (w5_s && src_tx5.size() > 0) begin
                void'(src_tx5.pop_front());
                if (fifo5_space > 0) fifo5_space--;
            end
            drive();
        end
    end

    // Monitor / scoreboard.
    logic [1:0] prev_adr = 2'b00;
    logic       mon_in_burst = 1'b0;
    int         mon_run = 0;
    logic       pkt_next = 1'b0;
    logic [1:0] pkt_adr = 2'b00;
    logic [8:0] e9;
    logic [7:0] e8;

    always @(negedge FX2_CLK) begin
        if (reset) begin
            mon_in_burst = 1'b0;
            mon_run      = 0;
            pkt_next     = 1'b0;
        end else begin
            if (FIFO_DATAOUT_OE && FIFO_DATAIN_OE) fail_now("oe_both_high");
            if (FIFO_FIFOADR != prev_adr) begin
                chk("turn_strobes", {FIFO_RD, FIFO_WR}, 0);
                chk("turn_dout_oe", FIFO_DATAOUT_OE, 0);
            end
            if (pkt_next) begin
                chk("pktend", FIFO_PKTEND, 1);
                chk("pktend_adr", FIFO_FIFOADR, pkt_adr);
                chk("pktend_dout_oe", FIFO_DATAOUT_OE, 0);
                pkt_next = 1'b0;
            end else if (FIFO_PKTEND) begin
                fail_now($sformatf("unexpected_pktend adr=%b", FIFO_FIFOADR));
            end
            if (FIFO_RD) begin
                chk("rd_adr", FIFO_FIFOADR, 2'b00);
                chk("rd_rx_valid", rx_valid, 1);
                if (exp_rx.size() == 0) begin
                    fail_now($sformatf("unexpected_rd data=%h", rx_data));
                end else begin
                    e8 = exp_rx.pop_front();
                    chk("rx_data", rx_data, e8);
                end
            end
            if (FIFO_WR) begin
                chk("wr_dout_oe", FIFO_DATAOUT_OE, 1);
                if (FIFO_FIFOADR == 2'b10) begin
                    chk("wr4_tx4_ready", tx4_ready, 1);
                    chk("wr4_tx5_ready", tx5_ready, 0);
                    if (exp_tx4.size() == 0) begin
                        fail_now($sformatf("unexpected_wr4 data=%h", FIFO_DATAOUT));
                    end else begin
                        e9 = exp_tx4.pop_front();
                        chk("tx4_fd", FIFO_DATAOUT, e9[7:0]);
                        if (e9[8]) begin pkt_next = 1'b1; pkt_adr = 2'b10; end
                    end
                    wr4_cnt++;
                end else if (FIFO_FIFOADR == 2'b11) begin
                    chk("wr5_tx5_ready", tx5_ready, 1);
                    chk("wr5_tx4_ready", tx4_ready, 0);
                    if (exp_tx5.size() == 0) begin
                        fail_now($sformatf("unexpected_wr5 data=%h", FIFO_DATAOUT));
                    end else begin
                        e9 = exp_tx5.pop_front();
                        chk("tx5_fd", FIFO_DATAOUT, e9[7:0]);
                        if (e9[8]) begin pkt_next = 1'b1; pkt_adr = 2'b11; end
                    end
                end else begin
                    fail_now($sformatf("wr_bad_adr adr=%b", FIFO_FIFOADR));
                end
            end
            if (FIFO_RD || FIFO_WR) begin
                if (!mon_in_burst) begin
                    grant_log.push_back(FIFO_FIFOADR);
                    mon_run = 0;
                end
                mon_run++;
                mon_in_burst = 1'b1;
            end else if (mon_in_burst) begin
                len_log.push_back(mon_run);
                mon_in_burst = 1'b0;
            end
        end
        prev_adr = FIFO_FIFOADR;
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((src_rx.size() + src_tx4.size() + src_tx5.size()) != 0 && n < 400) begin
            @(posedge FX2_CLK);
            n++;
        end
        repeat (4) @(posedge FX2_CLK);
        #1;
        if (n >= 400) fail_now($sformatf("%s_timeout: sources not drained after %0d cycles", name, n));
    endtask

    task automatic check_logs(input string name);
        chk($sformatf("%s_nbursts", name), grant_log.size(), eg_q.size());
        for (int i = 0; i < eg_q.size() && i < grant_log.size(); i++)
            chk($sformatf("%s_grant%0d", name, i), grant_log[i], eg_q[i]);
        chk($sformatf("%s_nlens", name), len_log.size(), el_q.size());
        for (int i = 0; i < el_q.size() && i < len_log.size(); i++)
            chk($sformatf("%s_len%0d", name, i), len_log[i], el_q[i]);
        grant_log.delete();
        len_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        // Reset values, before any clock edge.
        #3;
        chk("rst_fifoadr", FIFO_FIFOADR, 2'b00);
        chk("rst_datain_oe", FIFO_DATAIN_OE, 1);
        chk("rst_dataout_oe", FIFO_DATAOUT_OE, 0);
        chk("rst_strobes", {FIFO_RD, FIFO_WR, FIFO_PKTEND}, 0);
        chk("rst_dataout", FIFO_DATAOUT, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_ready", {tx4_ready, tx5_ready}, 0);
        @(posedge FX2_CLK);
        @(posedge FX2_CLK);
        #1 reset = 1'b0;
        rx_ready_en = 1'b1;

        // RX only: 5 bytes, MAX_BURST=4 splits 4+1, address never changes.
        for (int i = 0; i < 5; i++) push_rx(8'h11 + 8'(i));
        wait_idle("rx");
        eg_q = '{2'b00, 2'b00};
        el_q = '{4, 1};
        check_logs("rx");

        // TX4 packet with turnaround and commit.
        push_tx4(1'b0, 8'hA0);
        push_tx4(1'b0, 8'hA1);
        push_tx4(1'b1, 8'hA2);
        wait_idle("tx4pkt");
        eg_q = '{2'b10};
        el_q = '{3};
        check_logs("tx4pkt");

        // Contention: pointer sits on FIFO5 after the FIFO4 packet.
        for (int i = 0; i < 8; i++) begin
            push_rx(8'h20 + 8'(i));
            push_tx4(1'b0, 8'h40 + 8'(i));
            push_tx5(1'b0, 8'h50 + 8'(i));
        end
        wait_idle("contention");
        eg_q = '{2'b11, 2'b00, 2'b10, 2'b11, 2'b00, 2'b10};
        el_q = '{4, 4, 4, 4, 4, 4};
        check_logs("contention");

        // last on the MAX_BURST-th byte still commits.
        push_tx5(1'b0, 8'h60);
        push_tx5(1'b0, 8'h61);
        push_tx5(1'b0, 8'h62);
        push_tx5(1'b1, 8'h63);
        wait_idle("tx5max");
        eg_q = '{2'b11};
        el_q = '{4};
        check_logs("tx5max");

        // Back-pressure: FIFO4 fills after 2 writes of a 6-byte packet.
        fifo4_space = 2;
        for (int i = 0; i < 6; i++) push_tx4(i == 5, 8'hB0 + 8'(i));
        push_tx5(1'b0, 8'hC0);
        push_tx5(1'b1, 8'hC1);
        repeat (30) @(posedge FX2_CLK);
        #2;
        chk("bp_tx4_left", src_tx4.size(), 4);
        chk("bp_tx5_left", src_tx5.size(), 0);
        fifo4_space = 1000;
        wait_idle("backpressure");
        eg_q = '{2'b10, 2'b11, 2'b10};
        el_q = '{2, 2, 4};
        check_logs("backpressure");

        // Reset in the middle of a TX4 burst.
        base = wr4_cnt;
        push_tx4(1'b0, 8'hD0);
        push_tx4(1'b0, 8'hD1);
        push_tx4(1'b0, 8'hD2);
        push_tx4(1'b1, 8'hD3);
        n = 0;
        do begin
            @(posedge FX2_CLK);
            n++;
        end while (wr4_cnt < base + 2 && n < 200);
        if (n >= 200) fail_now("rst_tx_timeout: two writes never seen");
        #1;
        chk("rst_tx_mid_wr", FIFO_WR, 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_tx_wr", FIFO_WR, 0);
        chk("rst_tx_dout_oe", FIFO_DATAOUT_OE, 0);
        chk("rst_tx_pktend", FIFO_PKTEND, 0);
        chk("rst_tx_fifoadr", FIFO_FIFOADR, 2'b00);
        chk("rst_tx_datain_oe", FIFO_DATAIN_OE, 1);
        chk("rst_tx_tx4_ready", tx4_ready, 0);
        src_tx4.delete();
        exp_tx4.delete();
        @(posedge FX2_CLK);
        @(posedge FX2_CLK);
        #1 reset = 1'b0;
        repeat (6) @(posedge FX2_CLK);
        #1;
        grant_log.delete();
        len_log.delete();
        push_rx(8'hE0);
        push_rx(8'hE1);
        push_tx5(1'b1, 8'hF0);
        wait_idle("post_reset");
        eg_q = '{2'b00, 2'b11};
        el_q = '{2, 1};
        check_logs("post_reset");

        chk("exp_rx_left", exp_rx.size(), 0);
        chk("exp_tx4_left", exp_tx4.size(), 0);
        chk("exp_tx5_left", exp_tx5.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fx2_fifo_scheduler.md
Name: fx2_fifo_scheduler

Overview:
Sequences the shared FX2 slave-FIFO bus (FD, SLRD/SLWR, PKTEND, FIFOADR, bus output-enables) between three fabric requesters: the RX stream out of FIFO2 and the TX streams into FIFO4 and FIFO5. Sits directly behind the positive-logic FX2 renaming layer and replaces ad-hoc per-design state machines.
Arbitration is round-robin with bounded bursts, a bus turnaround whenever FIFOADR changes, and packet commit via PKTEND.

Parameters:
MAX_BURST, 64, maximum bytes moved per grant (1..255)
TURN_CYCLES, 1, idle bus cycles inserted when FIFOADR changes (1..3)

Ports:
FX2_CLK  in  1  FX2 interface clock, sole clock
reset  in  1  asynchronous, active-high reset
FIFO2_data_available  in  1  FIFO2 not empty
FIFO4_ready_to_accept_data  in  1  FIFO4 not full
FIFO5_ready_to_accept_data  in  1  FIFO5 not full
FIFO_DATAIN  in  8  FD bus read value
FIFO_DATAOUT  out  8  FD bus drive value
FIFO_DATAOUT_OE  out  1  drive FD
FIFO_DATAIN_OE  out  1  FX2 SLOE (FX2 drives FD)
FIFO_RD  out  1  read strobe
FIFO_WR  out  1  write strobe
FIFO_PKTEND  out  1  commit packet
FIFO_FIFOADR  out  2  selected FIFO
rx_data  out  8  byte from FIFO2
rx_valid  out  1  rx_data valid
rx_ready  in  1  sink accepts
tx4_data, tx5_data  in  8  bytes for FIFO4 / FIFO5
tx4_valid, tx5_valid  in  1  byte present
tx4_last, tx5_last  in  1  byte ends packet
tx4_ready, tx5_ready  out  1  byte accepted this cycle

Behaviour:
- Reset (async): state IDLE; FIFO_FIFOADR=2'b00; FIFO_DATAIN_OE=1; FIFO_DATAOUT_OE=0; FIFO_RD, FIFO_WR, FIFO_PKTEND=0; FIFO_DATAOUT=0; rx_valid=0; tx*_ready=0; RR pointer=FIFO2; burst counter=0.
- Requests: RXreq = FIFO2_data_available & rx_ready. TX4req = tx4_valid & FIFO4_ready_to_accept_data. TX5req likewise for FIFO5.
- States: IDLE, TURN, RX, TX, PKTEND.
- IDLE: if any request is active, grant the first requester after the last-served one in order FIFO2→FIFO4→FIFO5. Register FIFOADR to the grantee: FIFO2=00, FIFO4=10, FIFO5=11. If the address changes, go to TURN; otherwise go directly to RX or TX.
- TURN: lasts TURN_CYCLES cycles. RD, WR and DATAOUT_OE are 0. DATAIN_OE=1 only if the grantee is FIFO2. Then go to RX or TX.
- RX:
  - DATAIN_OE=1.
  - rx_valid = FIFO2_data_available (combinational).
  - rx_data = FIFO_DATAIN.
  - FIFO_RD = rx_valid & rx_ready.
  - Each RD increments the burst counter.
- TX:
  - DATAIN_OE=0.
  - DATAOUT_OE=1.
  - FIFO_DATAOUT = data from the granted channel.
  - FIFO_WR = txN_valid & FIFOn ready.
  - txN_ready = FIFO_WR.
  - The non-granted channel sees ready=0.
- Burst end, evaluated each cycle:
  - If the enabling flag, valid or rx_ready is low, no strobe issues that cycle and the state returns to IDLE.
  - If the counter reaches MAX_BURST with that cycle's strobe, return to IDLE after the strobe.
  - A TX write with txN_last=1 goes to PKTEND.
- PKTEND: one cycle with FIFO_PKTEND=1. FIFOADR is unchanged and DATAOUT_OE=0. Then go to IDLE.
- last on the MAX_BURST-th byte: PKTEND is still issued.
- On every return to IDLE, clear the counter and advance the RR pointer past the grantee.
- Counter width is $clog2(MAX_BURST+1). It never wraps.
- DATAOUT_OE and DATAIN_OE are never both 1.
- Reset mid-burst aborts immediately. No PKTEND is generated, and partial FX2 packets remain uncommitted.

Decomposition:
- Package fx2_sched_pkg:
  - state enum.
  - FIFOADR constants: FIFO2=2'b00, FIFO4=2'b10, FIFO5=2'b11.
  - requester index constants.
- Sub-module fx2_rr_arbiter: 3-way round-robin with one-hot grant, pointer update on a release pulse.
- The top level holds the FSM, counter, muxes and strobes.

Test Plan:
- Reset: assert reset mid-cycle → all outputs take reset values asynchronously; FIFOADR=00, DATAIN_OE=1.
- RX only: FIFO2 holds 5 bytes 0x11..0x15, rx_ready=1 → no TURN (address already 00); 5 consecutive RD pulses; rx_data matches in order; IDLE when the flag drops.
- TX4 packet: 3 bytes 0xA0..0xA2, last on 0xA2 → TURN 1 cycle (FIFOADR=10, OE both 0), 3 WR cycles with matching FD, 1 PKTEND cycle, then IDLE.
- Contention, MAX_BURST=4: all three requesters permanently active → grants FIFO2, FIFO4, FIFO5, FIFO2…; exactly 4 strobes each; a TURN between each grant; no PKTEND.
- Back-pressure: FIFO4_ready drops after 2 writes of a 6-byte burst → WR and tx4_ready are 0 that same cycle; state goes to IDLE; the next grant is FIFO5 or FIFO2; FIFO4 resumes later with no byte lost or duplicated.
- Reset during TX: reset asserted after 2 writes → WR, DATAOUT_OE and PKTEND go to 0 immediately; no PKTEND after release; next grant starts from the FIFO2 pointer.
